// File: rtl/div_pkg.sv
// Shared types and constants for the restoring-division sequencer (div_ctrl).
// Holds the FSM state encoding, the default operand width and the counter-width rule.
package div_pkg;

  localparam int DIV_N = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_CMP   = 3'd3,
    S_DONE  = 3'd4
  } div_state_e;

  // Iteration counter / bit-select width; never narrower than one bit.
  function automatic int div_cw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Handshake/strobe bundle between the division controller and its datapath/command side.
// The master drives requests and datapath flags; the slave (div_ctrl) drives strobes and results.
interface div_ctrl_if
  import div_pkg::*;
#(
  parameter int N = DIV_N
);

  localparam int CW = div_cw(N);

  logic          start;
  logic          divisor_zero;
  logic          ge;
  logic          busy;
  logic          done;
  logic          load;
  logic          shift;
  logic          sub_en;
  logic [CW-1:0] bit_sel;
  logic [N-1:0]  q;
  logic          dz;

  modport master (
    output start, divisor_zero, ge,
    input  busy, done, load, shift, sub_en, bit_sel, q, dz
  );

  modport slave (
    input  start, divisor_zero, ge,
    output busy, done, load, shift, sub_en, bit_sel, q, dz
  );

endinterface

// File: rtl/div_iter_cnt.sv
// Iteration down-counter for div_ctrl: loads N-1, decrements on request, flags zero.
// Decrement is blocked at zero so the count can never wrap.
module div_iter_cnt
  import div_pkg::*;
#(
  parameter int N  = DIV_N,
  parameter int CW = div_cw(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          zero_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(N - 1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/div_ctrl.sv
// Sequencer for a restoring long-division datapath: LOAD, then N SHIFT/CMP pairs MSB first, then DONE.
// Optional DIV_ZERO_CHECK_EN: a zero divisor seen in LOAD skips straight to DONE with q=all ones, dz=1.
module div_ctrl
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           clk,
  input  logic           rst,
  div_ctrl_if.slave      bus
);

  localparam int CW = div_cw(N);

  div_state_e    state_q;
  div_state_e    state_d;
  logic [N-1:0]  q_q;
  logic [N-1:0]  q_d;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          cnt_load;
  logic          cnt_dec;

  assign cnt_load = (state_q == S_LOAD);
  assign cnt_dec  = (state_q == S_CMP) && !cnt_zero;

  div_iter_cnt #(
    .N  (N),
    .CW (CW)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_load),
    .dec_i  (cnt_dec),
    .cnt_o  (cnt),
    .zero_o (cnt_zero)
  );

`ifdef DIV_ZERO_CHECK_EN
  logic dz_q;
  logic dz_d;
`else
  logic unused_divisor_zero;
  assign unused_divisor_zero = bus.divisor_zero;
`endif

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
`ifdef DIV_ZERO_CHECK_EN
    dz_d    = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        q_d     = '0;
        state_d = S_SHIFT;
`ifdef DIV_ZERO_CHECK_EN
        dz_d    = 1'b0;
        if (bus.divisor_zero) begin
          q_d     = '1;
          dz_d    = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_SHIFT: begin
        state_d = S_CMP;
      end
      S_CMP: begin
        // Quotient bits arrive MSB first, so shift them in from the right.
        q_d     = {q_q[N-2:0], bus.ge};
        state_d = cnt_zero ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
`ifdef DIV_ZERO_CHECK_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
`ifdef DIV_ZERO_CHECK_EN
      dz_q    <= dz_d;
`endif
    end
  end

  // Strobes are decoded straight from state so an async reset drops them all at once.
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign bus.load    = (state_q == S_LOAD);
  assign bus.shift   = (state_q == S_SHIFT);
  assign bus.sub_en  = (state_q == S_CMP) && bus.ge;
  assign bus.bit_sel = (state_q == S_SHIFT) ? cnt : '0;
  assign bus.q       = q_q;
`ifdef DIV_ZERO_CHECK_EN
  assign bus.dz      = dz_q;
`else
  assign bus.dz      = 1'b0;
`endif

  a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst)
    $onehot0({bus.load, bus.shift, bus.sub_en, bus.done}));

  a_state_legal: assert property (@(posedge clk) disable iff (!rst)
    (state_q inside {S_IDLE, S_LOAD, S_SHIFT, S_CMP, S_DONE}));

endmodule
